// File: rtl/btn_event_capture.sv
// Capture stage behind the button debouncers: edge detect, sticky pending flags,
// saturating per-button press counters and a maskable interrupt on a 4-word bus.
module btn_event_capture #(
   parameter int unsigned N_BTN = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [N_BTN-1:0] btn_i,
   input  logic             we_i,
   input  logic [1:0]       addr_i,
   input  logic [31:0]      wdata_i,
   output logic [31:0]      rdata_o,
   output logic             irq_o
);

   typedef enum logic [1:0] {
      REG_LEVEL = 2'd0,
      REG_PEND  = 2'd1,
      REG_EN    = 2'd2,
      REG_COUNT = 2'd3
   } reg_e;

   reg_e                  sel;
   logic [N_BTN-1:0]      lvl_q;
   logic                  armed_q;
   logic [N_BTN-1:0]      pend_q, pend_d;
   logic [N_BTN-1:0]      en_q, en_d;
   logic [N_BTN-1:0][7:0] cnt_q, cnt_d;
   logic [N_BTN-1:0]      press;
   logic                  wr_pend, wr_en, wr_cnt;
   logic                  unused_wdata;

   assign sel          = reg_e'(addr_i);
   assign wr_pend      = we_i && (sel == REG_PEND);
   assign wr_en        = we_i && (sel == REG_EN);
   assign wr_cnt       = we_i && (sel == REG_COUNT);
   assign unused_wdata = ^wdata_i;

   // armed_q masks the edge seen when a button is held through reset release
   assign press = armed_q ? (btn_i & ~lvl_q) : '0;

   always_comb begin
      pend_d = pend_q;
      en_d   = en_q;
      cnt_d  = cnt_q;
      if (wr_pend) begin
         pend_d = pend_q & ~wdata_i[N_BTN-1:0];
      end
      pend_d = pend_d | press;
      if (wr_en) begin
         en_d = wdata_i[N_BTN-1:0];
      end
      for (int unsigned i = 0; i < N_BTN; i++) begin
         if (wr_cnt) begin
            cnt_d[i] = {7'd0, press[i]};
         end else if (press[i] && (cnt_q[i] != 8'hFF)) begin
            cnt_d[i] = cnt_q[i] + 8'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         lvl_q   <= '0;
         armed_q <= 1'b0;
         pend_q  <= '0;
         en_q    <= '0;
         cnt_q   <= '0;
      end else begin
         lvl_q   <= btn_i;
         armed_q <= 1'b1;
         pend_q  <= pend_d;
         en_q    <= en_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      rdata_o = '0;
      case (sel)
         REG_LEVEL: rdata_o[N_BTN-1:0]   = lvl_q;
         REG_PEND:  rdata_o[N_BTN-1:0]   = pend_q;
         REG_EN:    rdata_o[N_BTN-1:0]   = en_q;
         REG_COUNT: rdata_o[8*N_BTN-1:0] = cnt_q;
      endcase
   end

   assign irq_o = |(pend_q & en_q);

endmodule

// File: tb/tb_btn_event_capture.sv
// Bench for btn_event_capture: directed vector table, corner-case sequences and
// randomized traffic checked against a rule-level reference model.
module tb_btn_event_capture;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [3:0]  btn_i;
   logic        we_i;
   logic [1:0]  addr_i;
   logic [31:0] wdata_i;
   logic [31:0] rdata_o;
   logic        irq_o;

   always #5 clk_i = ~clk_i;

   btn_event_capture #(.N_BTN(4)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .btn_i   (btn_i),
      .we_i    (we_i),
      .addr_i  (addr_i),
      .wdata_i (wdata_i),
      .rdata_o (rdata_o),
      .irq_o   (irq_o)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state, expressed as plain per-button facts
   logic [3:0] m_lvl   = '0;
   bit         m_armed = 1'b0;
   logic [3:0] m_pend  = '0;
   logic [3:0] m_en    = '0;
   int         m_cnt [4] = '{0, 0, 0, 0};

   typedef struct {
      logic        rst;
      logic [3:0]  btn;
      logic        we;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [1:0]  chk_addr;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic [3:0] btn, input logic we,
                      input logic [1:0] addr, input logic [31:0] wdata,
                      input logic [1:0] chk, input logic [31:0] exp_rd, input logic exp_irq);
      vec_t v;
      v.rst = rst; v.btn = btn; v.we = we; v.addr = addr; v.wdata = wdata;
      v.chk_addr = chk; v.exp_rd = exp_rd; v.exp_irq = exp_irq;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_rd(input logic [1:0] a);
      case (a)
         2'd0:    return {28'd0, m_lvl};
         2'd1:    return {28'd0, m_pend};
         2'd2:    return {28'd0, m_en};
         default: return {8'(m_cnt[3]), 8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])};
      endcase
   endfunction

   task automatic model_update(input logic rst, input logic [3:0] btn, input logic we,
                               input logic [1:0] addr, input logic [31:0] wdata);
      bit pressed;
      if (!rst) begin
         m_lvl = '0; m_armed = 1'b0; m_pend = '0; m_en = '0;
         for (int i = 0; i < 4; i++) m_cnt[i] = 0;
         return;
      end
      for (int i = 0; i < 4; i++) begin
         pressed = m_armed && btn[i] && !m_lvl[i];
         if (we && addr == 2'd1 && wdata[i]) m_pend[i] = 1'b0;
         if (pressed) m_pend[i] = 1'b1;
         if (we && addr == 2'd3) m_cnt[i] = pressed ? 1 : 0;
         else if (pressed) m_cnt[i] = (m_cnt[i] >= 255) ? 255 : m_cnt[i] + 1;
      end
      if (we && addr == 2'd2) m_en = wdata[3:0];
      m_lvl   = btn;
      m_armed = 1'b1;
   endtask

   // One clock: drive, clock, advance model, then read back every address
   task automatic cycle(input logic rst, input logic [3:0] btn, input logic we,
                        input logic [1:0] addr, input logic [31:0] wdata);
      rst_i = rst; btn_i = btn; we_i = we; addr_i = addr; wdata_i = wdata;
      @(posedge clk_i);
      model_update(rst, btn, we, addr, wdata);
      #1;
      we_i = 1'b0;
      for (int a = 0; a < 4; a++) begin
         addr_i = 2'(a);
         #1;
         check("model_rdata", rdata_o, model_rd(2'(a)));
      end
      check("model_irq", {31'd0, irq_o}, {31'd0, |(m_pend & m_en)});
   endtask

   task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
      addr_i = a;
      #1;
      check(name, rdata_o, exp);
   endtask

   initial begin
      rst_i = 1'b0; btn_i = '0; we_i = 1'b0; addr_i = '0; wdata_i = '0;

      // reset with buttons held, then release
      add(0, 4'hF, 0, 0, 0,      0, 32'h0, 0);
      add(0, 4'hF, 0, 0, 0,      1, 32'h0, 0);
      add(1, 4'hF, 0, 0, 0,      0, 32'hF, 0);
      add(1, 4'hF, 0, 0, 0,      1, 32'h0, 0);
      add(1, 4'hF, 0, 0, 0,      3, 32'h0, 0);
      // single press on button 0
      add(1, 4'h0, 1, 2, 32'h1,  2, 32'h1, 0);
      add(1, 4'h1, 0, 0, 0,      1, 32'h1, 1);
      add(1, 4'h1, 0, 0, 0,      3, 32'h1, 1);
      add(1, 4'h1, 0, 0, 0,      0, 32'h1, 1);
      add(1, 4'h1, 0, 0, 0,      3, 32'h1, 1);
      add(1, 4'h1, 0, 0, 0,      1, 32'h1, 1);
      add(1, 4'h0, 1, 1, 32'h1,  1, 32'h0, 0);
      // press and W1C hit bit 1 together
      add(1, 4'h2, 1, 1, 32'h2,  1, 32'h2, 0);
      add(1, 4'h0, 0, 0, 0,      3, 32'h0000_0101, 0);

      foreach (vecs[k]) begin
         cycle(vecs[k].rst, vecs[k].btn, vecs[k].we, vecs[k].addr, vecs[k].wdata);
         rd_check("vec_rdata", vecs[k].chk_addr, vecs[k].exp_rd);
         check("vec_irq", {31'd0, irq_o}, {31'd0, vecs[k].exp_irq});
      end

      // saturation on button 2
      for (int n = 0; n < 300; n++) begin
         cycle(1, 4'h4, 0, 0, 0);
         cycle(1, 4'h0, 0, 0, 0);
      end
      rd_check("sat_count", 2'd3, 32'h00FF_0101);
      cycle(1, 4'h4, 1, 3, 32'h0);
      rd_check("clear_with_press", 2'd3, 32'h0001_0000);
      cycle(1, 4'h0, 0, 0, 0);

      // masked press on button 3, then unmask
      cycle(1, 4'h0, 1, 2, 32'h0);
      cycle(1, 4'h0, 1, 1, 32'hF);
      cycle(1, 4'h8, 0, 0, 0);
      rd_check("mask_pend", 2'd1, 32'h8);
      check("mask_irq_low", {31'd0, irq_o}, 32'h0);
      cycle(1, 4'h0, 1, 2, 32'h8);
      check("unmask_irq_high", {31'd0, irq_o}, 32'h1);

      // reset mid-operation with a coincident press and write
      cycle(1, 4'h0, 1, 2, 32'hF);
      cycle(1, 4'hF, 0, 0, 0);
      rd_check("pre_rst_pend", 2'd1, 32'hF);
      cycle(1, 4'h0, 0, 0, 0);
      cycle(0, 4'hF, 1, 1, 32'hF);
      for (int a = 0; a < 4; a++) rd_check("mid_rst_zero", 2'(a), 32'h0);
      check("mid_rst_irq", {31'd0, irq_o}, 32'h0);

      // randomized traffic against the model
      for (int n = 0; n < 2000; n++) begin
         cycle(($urandom_range(63) == 0) ? 1'b0 : 1'b1,
               4'($urandom_range(15)),
               ($urandom_range(3) == 0),
               2'($urandom_range(3)),
               $urandom());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
